mpmc11_app_responder: RTL
=========================

# mpmc11_app_responder

Synthesizable responder for the DDR user-interface (app_*) command/data protocol that the mpmc11 controller state machine drives. It accepts commands and write data, stores them in on-chip block RAM, returns read data after a fixed latency, models calibration and refresh, and exposes stall inputs for backpressure. It replaces the memory-interface IP in simulation and in FPGA builds without external DRAM.

## Interface
- ADDR_W, 29, app_addr width
- DATA_W, 256, data beat width; mask width DATA_W/8
- DEPTH_LOG2, 10, log2 of backing words (one word = one DATA_W beat)
- RD_LAT, 4, cycles from read retire to app_rd_data_valid (≥1)
- CALIB_CYCLES, 64, cycles after reset before calib_complete rises
- REF_CYCLES, 8, busy cycles per refresh
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- calib_complete  out  1  calibration done
- app_addr  in  ADDR_W  byte-group address; word index = app_addr[3 +: DEPTH_LOG2]
- app_cmd  in  3  3'b000 write, 3'b001 read
- app_en  in  1  command strobe
- app_rdy  out  1  command accept
- app_wdf_data  in  DATA_W  write data
- app_wdf_mask  in  DATA_W/8  byte mask; 1 = byte NOT written
- app_wdf_wren, app_wdf_end  in  1 each  data strobe / last beat (one beat per burst, end == wren)
- app_wdf_rdy  out  1  write-data accept
- app_rd_data  out  DATA_W  read data
- app_rd_data_valid, app_rd_data_end  out  1 each  read beat valid / last beat (equal)
- app_ref_req  in  1  refresh request pulse
- app_ref_ack  out  1  one-cycle refresh done
- stall_cmd, stall_wdf  in  1 each  force app_rdy / app_wdf_rdy low

## Operation
- States: CALIB, RUN, REF_DRAIN, REF_BUSY.
- CALIB: counter counts CALIB_CYCLES; then calib_complete=1, go RUN. app_rdy, app_wdf_rdy = 0 in CALIB.
- Command queue (4 entries, {cmd, word index}); command accepted when app_en & app_rdy. Unknown app_cmd accepted and dropped at retire.
- Write-data FIFO (4 entries, {data, mask}); beat accepted when app_wdf_wren & app_wdf_rdy. Data may precede its command by any number of beats up to FIFO depth, or follow it.
- app_rdy = RUN & !stall_cmd & !cmdq_full. app_wdf_rdy = calib_complete & !stall_wdf & !wdf_full.
- Retire, at most one per cycle, strict order: head read retires unconditionally; head write retires only when the write-data FIFO is non-empty, popping both and applying byte mask. No retire while head write lacks data (later reads wait: read-after-write order preserved).
- Read pipeline: RD_LAT-deep valid/data shift; always accepts one retire per cycle.
- Address bits above DEPTH_LOG2+3 ignored (aliasing wrap).
- Refresh: app_ref_req in RUN latches a pending flag; RUN→REF_DRAIN (app_rdy=0) until command queue and read pipeline empty; →REF_BUSY for REF_CYCLES; app_ref_ack=1 for one cycle on exit; →RUN. app_ref_req during REF_* ignored; during CALIB held pending.

## Timing
- Reset values: calib_complete=0, app_rdy=0, app_wdf_rdy=0, app_rd_data_valid=0, app_rd_data_end=0, app_ref_ack=0, app_rd_data=0; state=CALIB; queues and pipeline emptied. RAM contents not cleared.
- calib_complete rises at cycle CALIB_CYCLES after rst deasserts.
- Read accepted at cycle N into empty queue: retires N+1; app_rd_data_valid at N+1+RD_LAT (N+5 default). Back-to-back reads stream one beat per cycle.
- Write accepted at N with data already queued: RAM updated at N+1; read accepted at N+1 returns new data.
- Simultaneous push and pop of a full queue: pop first, push allowed only if not full at cycle start (app_rdy registered-combinational from current occupancy).
- Reset mid-operation: all in-flight reads dropped, no valid after reset, calibration restarts.

## Structure
- mpmc11_pkg gains APP_CMD_WRITE, APP_CMD_READ constants and mpmc11_resp_state_t enum (CALIB, RUN, REF_DRAIN, REF_BUSY).
- Sub-module mpmc11_resp_fifo: parameterized width/depth synchronous FIFO with full/empty/count, instantiated for command queue and write-data FIFO.

## Test plan
- Reset, idle: app_rdy=0 until cycle 64, then calib_complete=1, app_rdy=1.
- Data-first write 0xA5 pattern to addr 0x40 mask 0, then read 0x40 → app_rd_data_valid exactly 5 cycles after read accept, data 0xA5 pattern.
- Write command before data, then read same address accepted next cycle → read returns only after write data arrives, with new data.
- Mask 0x0000_000F over prior all-ones word, data 0 → read returns ones in low 4 bytes, zeros elsewhere.
- stall_cmd high with 4 queued reads → app_rdy=0; release → 4 consecutive valid beats, order preserved.
- app_ref_req with 2 reads in flight → both reads complete, app_rdy=0 for drain+8 cycles, single app_ref_ack pulse, then app_rdy=1.

Source files
------------

// File: rtl/mpmc11_pkg.sv
// Shared definitions for the mpmc11 app_* responder.
//   APP_CMD_*            app_cmd encodings understood by the responder
//   RESP_Q_DEPTH_LOG2    depth (log2) of the command queue and write-data FIFO
//   mpmc11_resp_state_t  responder top-level state
package mpmc11_pkg;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    localparam int RESP_Q_DEPTH_LOG2 = 2;

    typedef enum logic [1:0] {
        CALIB     = 2'd0,
        RUN       = 2'd1,
        REF_DRAIN = 2'd2,
        REF_BUSY  = 2'd3
    } mpmc11_resp_state_t;

endpackage

// File: rtl/mpmc11_resp_fifo.sv
// Small synchronous FIFO with first-word-fall-through head.
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   push, din    write strobe / data (ignored when full)
//   pop, dout    read strobe (ignored when empty) / current head
//   full, empty  occupancy flags from current count
//   count        number of stored entries
module mpmc11_resp_fifo #(
    parameter int W          = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [W-1:0]          din,
    input  logic                  pop,
    output logic [W-1:0]          dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [W-1:0]            store [DEPTH];
    logic [DEPTH_LOG2-1:0]   wptr, rptr;
    logic                    do_push, do_pop;

    // Flags come from occupancy at cycle start, so a full FIFO refuses a
    // push even when it is popped in the same cycle.
    assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = store[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wptr] <= din;
    end

endmodule

// File: rtl/mpmc11_app_responder.sv
// Behavioural DDR app_* responder backed by on-chip RAM.
//   clk, rst                          clock, synchronous active-high reset
//   calib_complete                    high once the calibration delay expires
//   app_addr/app_cmd/app_en/app_rdy   command channel (queued, 4 deep)
//   app_wdf_*                         write-data channel (queued, 4 deep)
//   app_rd_data*                      read return, RD_LAT cycles after retire
//   app_ref_req/app_ref_ack           refresh handshake
//   stall_cmd, stall_wdf              force backpressure on either channel
module mpmc11_app_responder
    import mpmc11_pkg::*;
#(
    parameter int ADDR_W       = 29,
    parameter int DATA_W       = 256,
    parameter int DEPTH_LOG2   = 10,
    parameter int RD_LAT       = 4,
    parameter int CALIB_CYCLES = 64,
    parameter int REF_CYCLES   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 calib_complete,
    input  logic [ADDR_W-1:0]    app_addr,
    input  logic [2:0]           app_cmd,
    input  logic                 app_en,
    output logic                 app_rdy,
    input  logic [DATA_W-1:0]    app_wdf_data,
    input  logic [DATA_W/8-1:0]  app_wdf_mask,
    input  logic                 app_wdf_wren,
    input  logic                 app_wdf_end,
    output logic                 app_wdf_rdy,
    output logic [DATA_W-1:0]    app_rd_data,
    output logic                 app_rd_data_valid,
    output logic                 app_rd_data_end,
    input  logic                 app_ref_req,
    output logic                 app_ref_ack,
    input  logic                 stall_cmd,
    input  logic                 stall_wdf
);
    localparam int MASK_W  = DATA_W / 8;
    localparam int CNT_MAX = (CALIB_CYCLES > REF_CYCLES) ? CALIB_CYCLES : REF_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef struct packed {
        logic [2:0]            cmd;
        logic [DEPTH_LOG2-1:0] idx;
    } cmd_ent_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] mask;
    } wdf_ent_t;

    mpmc11_resp_state_t state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               ref_pending;

    cmd_ent_t                    cmd_in, cmd_head;
    wdf_ent_t                    wdf_in, wdf_head;
    logic                        cmdq_full, cmdq_empty, wdf_full, wdf_empty;
    logic [RESP_Q_DEPTH_LOG2:0]  cmdq_cnt, wdf_cnt;
    logic                        cmd_push, wdf_push;
    logic                        retire, rd_retire, wr_retire;

    logic [RD_LAT:1]    vld_pipe;
    logic [DATA_W-1:0]  data_pipe [1:RD_LAT];
    logic [DATA_W-1:0]  mem [2**DEPTH_LOG2];

    assign app_rdy     = (state == RUN) && !stall_cmd && !cmdq_full;
    assign app_wdf_rdy = calib_complete && !stall_wdf && !wdf_full;
    assign cmd_push    = app_en && app_rdy;
    assign wdf_push    = app_wdf_wren && app_wdf_rdy;

    // Address bits above the RAM index alias onto the same word.
    assign cmd_in = {app_cmd, app_addr[3 +: DEPTH_LOG2]};
    assign wdf_in = {app_wdf_data, app_wdf_mask};

    mpmc11_resp_fifo #(.W($bits(cmd_ent_t)), .DEPTH_LOG2(RESP_Q_DEPTH_LOG2)) u_cmdq (
        .clk(clk), .rst(rst), .push(cmd_push), .din(cmd_in), .pop(retire),
        .dout(cmd_head), .full(cmdq_full), .empty(cmdq_empty), .count(cmdq_cnt)
    );

    mpmc11_resp_fifo #(.W($bits(wdf_ent_t)), .DEPTH_LOG2(RESP_Q_DEPTH_LOG2)) u_wdf (
        .clk(clk), .rst(rst), .push(wdf_push), .din(wdf_in), .pop(wr_retire),
        .dout(wdf_head), .full(wdf_full), .empty(wdf_empty), .count(wdf_cnt)
    );

    // In-order retire: a head write without data blocks everything behind
    // it, which keeps later reads from overtaking it.
    always_comb begin
        rd_retire = 1'b0;
        wr_retire = 1'b0;
        retire    = 1'b0;
        if (!cmdq_empty) begin
            case (cmd_head.cmd)
                APP_CMD_READ: begin
                    rd_retire = 1'b1;
                    retire    = 1'b1;
                end
                APP_CMD_WRITE: begin
                    wr_retire = !wdf_empty;
                    retire    = !wdf_empty;
                end
                default: retire = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CALIB:     if (cnt == CNT_W'(CALIB_CYCLES - 1)) state_nxt = RUN;
            RUN:       if (ref_pending || app_ref_req) state_nxt = REF_DRAIN;
            REF_DRAIN: if (cmdq_empty && !(|vld_pipe)) state_nxt = REF_BUSY;
            REF_BUSY:  if (cnt == CNT_W'(REF_CYCLES - 1)) state_nxt = RUN;
            default:   state_nxt = CALIB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= CALIB;
            cnt            <= '0;
            ref_pending    <= 1'b0;
            calib_complete <= 1'b0;
            app_ref_ack    <= 1'b0;
            vld_pipe       <= '0;
        end else begin
            state <= state_nxt;
            // Counter only matters in the timed states; restart on every entry.
            if (state_nxt != state || state == RUN || state == REF_DRAIN)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == CALIB && state_nxt == RUN)
                calib_complete <= 1'b1;
            app_ref_ack <= (state == REF_BUSY) && (state_nxt == RUN);
            // Requests seen during calibration wait for RUN; during a refresh
            // they are dropped.
            if (state == RUN && state_nxt == REF_DRAIN)
                ref_pending <= 1'b0;
            else if (app_ref_req && (state == CALIB || state == RUN))
                ref_pending <= 1'b1;
            vld_pipe[1] <= rd_retire;
            for (int i = 2; i <= RD_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // RAM and read-data pipeline carry no reset so they map onto block RAM;
    // the output is gated by the valid pipe instead.
    always_ff @(posedge clk) begin
        if (wr_retire) begin
            for (int b = 0; b < MASK_W; b++)
                if (!wdf_head.mask[b])
                    mem[cmd_head.idx][b*8 +: 8] <= wdf_head.data[b*8 +: 8];
        end
        data_pipe[1] <= mem[cmd_head.idx];
        for (int i = 2; i <= RD_LAT; i++)
            data_pipe[i] <= data_pipe[i-1];
    end

    assign app_rd_data_valid = vld_pipe[RD_LAT];
    assign app_rd_data_end   = vld_pipe[RD_LAT];
    assign app_rd_data       = vld_pipe[RD_LAT] ? data_pipe[RD_LAT] : '0;

    logic unused;
    assign unused = &{1'b0, app_addr[ADDR_W-1:DEPTH_LOG2+3], app_addr[2:0],
                      app_wdf_end, cmdq_cnt, wdf_cnt};

endmodule
